// File: rtl/noc_pkg.sv
// Shared NoC flit/credit field widths and arbiter state encoding.
// Used by the injection arbiter, its testbench and node blocks.
package noc_pkg;

    localparam int FLIT_DATA_W = 64;
    localparam int DEST_W      = 5;
    localparam int VC_W        = 2;

    function automatic int flit_width(input int dw, input int db, input int vb);
        return 2 + dw + db + vb;
    endfunction

    function automatic int credit_width(input int vb);
        return 1 + vb;
    endfunction

    localparam int FLIT_W   = flit_width(FLIT_DATA_W, DEST_W, VC_W);
    localparam int CREDIT_W = credit_width(VC_W);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin pick: first requester at or above ptr, wrapping.
// Returns one-hot grant, its index and an any-request flag.
module noc_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // scan N slots starting at ptr, keep the first valid one
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IW-1:0] j;
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Shares one NoC injection port among NUM_REQ requesters with
// packet-granular round-robin and per-VC credit flow control.
module noc_tx_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int FLIT_DATA_WIDTH = FLIT_DATA_W,
    parameter int DEST_BITS       = DEST_W,
    parameter int VC_BITS         = VC_W,
    parameter int CREDIT_DEPTH    = 16
) (
    input  logic                                  sys_clk,
    input  logic                                  nreset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_tail,
    input  logic [NUM_REQ*DEST_BITS-1:0]          req_dest,
    input  logic [NUM_REQ*VC_BITS-1:0]            req_vc,
    input  logic [NUM_REQ*FLIT_DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [flit_width(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS)-1:0] putFlit,
    output logic                                  EN_putFlit,
    input  logic [credit_width(VC_BITS)-1:0]      getCredits,
    output logic                                  EN_getCredits,
    output logic                                  busy,
    output logic                                  credit_err
);

    localparam int NUM_VCS = 2 ** VC_BITS;
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW      = $clog2(CREDIT_DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDIT_DEPTH);

    logic [0:0]           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        rr_ptr;
    logic [DEST_BITS-1:0] head_dest;
    logic [VC_BITS-1:0]   head_vc;
    logic [CW-1:0]        credit [NUM_VCS];

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;

    logic [IW-1:0]              sel;
    logic [IW-1:0]              next_ptr;
    logic                       sel_vld;
    logic [NUM_REQ-1:0]         sel_onehot;
    logic                       accept;
    logic                       f_tail;
    logic [DEST_BITS-1:0]       f_dest;
    logic [VC_BITS-1:0]         f_vc;
    logic [FLIT_DATA_WIDTH-1:0] f_data;
    logic [NUM_VCS-1:0]         use_v;
    logic [NUM_VCS-1:0]         ret_v;

    noc_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign busy          = (state == ST_LOCKED);
    assign EN_getCredits = nreset;

    // pick the eligible requester and build the outgoing flit
    always_comb begin
        sel             = owner;
        sel_vld         = req_valid[owner];
        f_dest          = head_dest;
        f_vc            = head_vc;
        sel_onehot      = '0;
        sel_onehot[owner] = 1'b1;
        if (state == ST_IDLE) begin
            sel        = arb_idx;
            sel_vld    = arb_any;
            f_dest     = req_dest[arb_idx*DEST_BITS +: DEST_BITS];
            f_vc       = req_vc[arb_idx*VC_BITS +: VC_BITS];
            sel_onehot = arb_grant;
        end
        accept    = nreset && sel_vld && (credit[f_vc] != '0);
        f_tail    = req_tail[sel];
        f_data    = req_data[sel*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
        req_ready = accept ? sel_onehot : '0;
        next_ptr  = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end

    // per-VC consume / return strobes
    always_comb begin
        use_v = '0;
        ret_v = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            use_v[v] = accept && (f_vc == VC_BITS'(v));
            ret_v[v] = getCredits[VC_BITS] &&
                       (getCredits[VC_BITS-1:0] == VC_BITS'(v));
        end
    end

    // packet lock, round-robin pointer and registered flit output
    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            head_dest  <= '0;
            head_vc    <= '0;
            putFlit    <= '0;
            EN_putFlit <= 1'b0;
        end else begin
            EN_putFlit <= accept;
            putFlit    <= accept ? {1'b1, f_tail, f_dest, f_vc, f_data} : '0;
            if (accept) begin
                if (f_tail) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_ptr;
                end else if (state == ST_IDLE) begin
                    state     <= ST_LOCKED;
                    owner     <= sel;
                    head_dest <= f_dest;
                    head_vc   <= f_vc;
                end
            end
        end
    end

    // credit counters; a return to a full VC saturates and flags
    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            for (int v = 0; v < NUM_VCS; v++) credit[v] <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (use_v[v] && !ret_v[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end else if (ret_v[v] && !use_v[v]) begin
                    if (credit[v] == CRED_MAX) credit_err <= 1'b1;
                    else credit[v] <= credit[v] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Self-checking bench for noc_tx_arbiter: directed scenarios
// plus randomized traffic against a packet-level reference model.
module tb_noc_tx_arbiter;
    import noc_pkg::*;

    logic               sys_clk;
    logic               nreset;
    logic [3:0]         req_valid;
    logic [3:0]         req_tail;
    logic [19:0]        req_dest;
    logic [7:0]         req_vc;
    logic [255:0]       req_data;
    logic [3:0]         req_ready;
    logic [FLIT_W-1:0]  putFlit;
    logic               EN_putFlit;
    logic [CREDIT_W-1:0] getCredits;
    logic               EN_getCredits;
    logic               busy;
    logic               credit_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_owner;
    int          m_rr;
    int          m_hdest;
    int          m_hvc;
    int          m_cred [4];
    bit          m_err;
    logic [72:0] m_put;
    bit          m_en;

    noc_tx_arbiter dut (
        .sys_clk       (sys_clk),
        .nreset        (nreset),
        .req_valid     (req_valid),
        .req_tail      (req_tail),
        .req_dest      (req_dest),
        .req_vc        (req_vc),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .putFlit       (putFlit),
        .EN_putFlit    (EN_putFlit),
        .getCredits    (getCredits),
        .EN_getCredits (EN_getCredits),
        .busy          (busy),
        .credit_err    (credit_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_hdest = 0;
        m_hvc   = 0;
        m_err   = 0;
        m_put   = '0;
        m_en    = 0;
        for (int v = 0; v < 4; v++) m_cred[v] = 16;
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_tail   = '0;
        req_dest   = '0;
        req_vc     = '0;
        req_data   = '0;
        getCredits = '0;
    endtask

    // called at posedge+1; returns at the next posedge+1
    task automatic do_reset();
        nreset = 1'b0;
        #1;
        chk("rst_en", EN_putFlit, 0);
        chk("rst_flit", putFlit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cerr", credit_err, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_engc", EN_getCredits, 0);
        model_reset();
        clear_inputs();
        @(posedge sys_clk);
        #1;
        nreset = 1'b1;
    endtask

    // check outputs against the model, then advance it by one clock
    task automatic step();
        int sel;
        int vc;
        int dest;
        bit acc;
        bit tl;
        logic [63:0] dat;
        logic [3:0]  rdy;
        #1;
        sel  = -1;
        vc   = 0;
        dest = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_rr + k) % 4;
                if (sel < 0 && req_valid[j]) sel = j;
            end
            if (sel >= 0) begin
                vc   = int'(req_vc[sel*2 +: 2]);
                dest = int'(req_dest[sel*5 +: 5]);
            end
        end else begin
            if (req_valid[m_owner]) sel = m_owner;
            vc   = m_hvc;
            dest = m_hdest;
        end
        acc = (sel >= 0) && (m_cred[vc] > 0);
        rdy = 4'b0;
        tl  = 0;
        dat = '0;
        if (acc) begin
            rdy[sel] = 1'b1;
            tl  = req_tail[sel];
            dat = req_data[sel*64 +: 64];
        end
        chk("en", EN_putFlit, m_en);
        chk("flit", putFlit, m_put);
        chk("busy", busy, m_owner >= 0);
        chk("cerr", credit_err, m_err);
        chk("rdy", req_ready, rdy);
        chk("engc", EN_getCredits, 1);
        m_en  = acc;
        m_put = acc ? {1'b1, tl, 5'(dest), 2'(vc), dat} : 73'b0;
        for (int v = 0; v < 4; v++) begin
            bit u;
            bit r;
            u = acc && (vc == v);
            r = getCredits[2] && (int'(getCredits[1:0]) == v);
            if (u && !r) m_cred[v]--;
            else if (r && !u) begin
                if (m_cred[v] == 16) m_err = 1;
                else m_cred[v]++;
            end
        end
        if (acc) begin
            if (tl) begin
                m_owner = -1;
                m_rr    = (sel + 1) % 4;
            end else if (m_owner < 0) begin
                m_owner = sel;
                m_hdest = dest;
                m_hvc   = vc;
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int acc_cnt;
        nreset = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge sys_clk);
        #1;
        req_valid = 4'b1111;
        do_reset();

        // two single-flit requesters from reset
        req_data  = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        req_tail  = 4'b1111;
        req_valid = 4'b0101;
        step();
        chk("s38_en1", EN_putFlit, 1);
        chk("s38_src0", putFlit[63:0], 64'hD0);
        chk("s38_rdy2", req_ready, 4'b0100);
        step();
        chk("s38_src2", putFlit[63:0], 64'hD2);
        req_valid = 4'b1001;
        #1;
        chk("s38_ptr3", req_ready, 4'b1000);
        step();

        // three-flit packet from req 1 while req 0 waits
        do_reset();
        req_data  = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        req_tail  = 4'b0001;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0011;
        req_tail  = 4'b0001;
        req_dest  = {5'd0, 5'd0, 5'd5, 5'd9};
        req_vc    = {2'd0, 2'd0, 2'd2, 2'd1};
        step();
        chk("s39_h_dest", putFlit[70:66], 5);
        chk("s39_h_vc", putFlit[65:64], 2);
        chk("s39_h_tail", putFlit[71], 0);
        req_dest = {5'd0, 5'd0, 5'd7, 5'd9};
        req_vc   = {2'd0, 2'd0, 2'd0, 2'd1};
        step();
        chk("s39_b_dest", putFlit[70:66], 5);
        chk("s39_b_vc", putFlit[65:64], 2);
        chk("s39_b_tail", putFlit[71], 0);
        req_tail = 4'b0011;
        step();
        chk("s39_t_dest", putFlit[70:66], 5);
        chk("s39_t_tail", putFlit[71], 1);
        chk("s39_next0", req_ready, 4'b0001);
        step();

        // exhaust vc 0 credits, then return one
        do_reset();
        req_valid = 4'b0001;
        acc_cnt   = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (EN_putFlit) acc_cnt++;
        end
        chk("s40_cnt", acc_cnt, 16);
        chk("s40_stall", EN_putFlit, 0);
        chk("s40_busy", busy, 1);
        getCredits = 3'b100;
        step();
        getCredits = 3'b000;
        chk("s40_wait", EN_putFlit, 0);
        step();
        chk("s40_resume", EN_putFlit, 1);
        step();

        // same-cycle use and return on vc 1 at full credit
        do_reset();
        req_valid  = 4'b0010;
        req_tail   = 4'b0010;
        req_vc     = 8'b0000_0100;
        getCredits = 3'b101;
        step();
        req_valid  = 4'b0000;
        getCredits = 3'b000;
        step();
        chk("s41_noerr", credit_err, 0);
        getCredits = 3'b101;
        step();
        getCredits = 3'b000;
        step();
        chk("s41_full", credit_err, 1);

        // return to a full vc 3
        do_reset();
        getCredits = 3'b111;
        step();
        getCredits = 3'b000;
        step();
        chk("s42_err", credit_err, 1);

        // reset in the middle of a four-flit packet
        do_reset();
        req_valid = 4'b0001;
        req_vc    = 8'b0000_0001;
        step();
        step();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        chk("s43_quiet", EN_putFlit, 0);
        chk("s43_idle", busy, 0);
        getCredits = 3'b101;
        step();
        getCredits = 3'b000;
        step();
        chk("s43_cred16", credit_err, 1);

        // randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int v;
            if (c % 600 == 599) do_reset();
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = ($urandom % 10) < 6;
                req_tail[i]  = ($urandom % 3) == 0;
            end
            req_dest = 20'($urandom);
            req_vc   = 8'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
            v = int'($urandom % 4);
            getCredits = '0;
            if (($urandom % 3) == 0 && (m_cred[v] < 16 || ($urandom % 20) == 0))
                getCredits = {1'b1, 2'(v)};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
